mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shared single-port memory arbiter for the 5-stage pipelined core. It sequences the instruction fetch port (F stage) and the data port (M stage) onto one unified memory with fixed read latency, holding one access in flight at a time. It raises per-stage stall requests that the hazard unit folds into the pipeline stall and flush controls.

## Interface
- DATA_WIDTH, 32, data and instruction word width
- ADDR_WIDTH, 32, byte address width
- MEM_LATENCY, 2, cycles from memory-enable cycle to read data valid; legal range 1..15

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; asserted when 0
- if_req  in  1  fetch request; held until if_valid
- if_addr  in  ADDR_WIDTH  fetch address (PCF)
- if_rdata  out  DATA_WIDTH  fetched instruction; meaningful only while if_valid=1
- if_valid  out  1  one-cycle completion pulse for fetch
- dm_req  in  1  data request; held until dm_valid
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_WIDTH  data address (ALUResultM)
- dm_wdata  in  DATA_WIDTH  store data (WriteDataM)
- dm_rdata  out  DATA_WIDTH  load data; meaningful only while dm_valid=1
- dm_valid  out  1  one-cycle completion pulse for data
- mem_en  out  1  memory access strobe, exactly one cycle per access
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  ADDR_WIDTH  memory address, held from ISSUE through end of WAIT
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data
- StallF  out  1  if_req & ~if_valid
- StallM  out  1  dm_req & ~dm_valid

## Operation
- The FSM has three states: IDLE, ISSUE, WAIT.
- IDLE: if no request is pending, stay in IDLE. If exactly one of if_req or dm_req is high, grant it. If both are high, grant the requester that was not granted last. On a grant, register the address, data, write enable and grant ID, then move to ISSUE.
- last_grant resets to FETCH, so the first conflict after reset goes to data.
- ISSUE: lasts one cycle. mem_en=1, and mem_we equals the registered write enable (forced to 0 for fetch). Load the counter with MEM_LATENCY-1, then move to WAIT.
- WAIT: decrement the counter each cycle. When the counter reads 0, pulse the valid output of the granted requester. In that same cycle, drive mem_rdata combinationally onto its rdata output. Update last_grant and return to IDLE.
- Stores use the same sequence and latency. dm_valid marks store completion, and dm_rdata is don't-care.
- The non-granted requester's rdata holds its last value and its valid stays 0.
- A request that drops before its valid pulse is a protocol violation. The access still completes.
- Requests are sampled only in IDLE. Requests arriving during ISSUE or WAIT wait, and their stall stays asserted.
- Reset mid-access: state goes to IDLE. mem_en, mem_we, if_valid and dm_valid go to 0. mem_addr, mem_wdata and the internal counter go to 0. The in-flight read data is discarded.

## Timing
- Reset values: all outputs are 0, last_grant=FETCH, state IDLE.
- For a request first seen in IDLE at cycle 0:
  - mem_en is high in cycle 1.
  - valid is high in cycle 1+MEM_LATENCY.
  - The FSM is in IDLE in cycle 2+MEM_LATENCY.
- Access period is MEM_LATENCY+2 cycles. There is no back-to-back issue.
- Stalls are combinational from the registered valid pulses, so StallF/StallM drop in the valid cycle. The pipeline advances at the following edge.
- The counter is 4 bits wide. MEM_LATENCY=1 gives exactly one WAIT cycle.

## Structure
- Package mem_arb_pkg holds:
  - arb_state_t enum: IDLE, ISSUE, WAIT
  - grant_t enum: FETCH, DATA
  - localparam CNT_W = 4
- Sub-module lat_counter: a loadable down-counter with a zero flag, async active-low reset, and `load`, `en` and `value` ports.
- The top-level module holds the FSM, grant registers and output muxing.

## Test plan
1. Fetch only, MEM_LATENCY=2, if_req=1, if_addr=0x0000_0010, memory returns 0x0050_0093 -> mem_en in cycle 1 with mem_addr=0x10, if_valid and if_rdata=0x0050_0093 in cycle 3, StallF=1 in cycles 0–2.
2. Store only, dm_we=1, dm_addr=0x100, dm_wdata=0xDEAD_BEEF -> mem_en=mem_we=1 for exactly cycle 1, dm_valid in cycle 3.
3. Simultaneous if_req and dm_req right after reset -> data served first (dm_valid in cycle 3), fetch issued in cycle 5 with if_valid in cycle 7, StallF=1 in cycles 0–6.
4. Both requesters held continuously for 4 accesses -> grant order DATA, FETCH, DATA, FETCH, one mem_en every 4 cycles.
5. Reset pulled low during WAIT of a load -> all outputs 0 within the same cycle (async), no dm_valid afterwards, a fresh request after release completes normally.
6. MEM_LATENCY=1, fetch at 0x4 -> mem_en in cycle 1, if_valid in cycle 2, IDLE in cycle 3.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package mem_arb_pkg;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } grant_t;

    // Registered description of the access currently owning the memory.
    typedef struct packed {
        grant_t id;
        logic   we;
    } grant_info_t;

    // Single requester wins outright; on conflict the one not served last wins.
    function automatic grant_t pick_grant(input logic   if_req,
                                          input logic   dm_req,
                                          input grant_t last);
        grant_t g;
        if (if_req && dm_req) begin
            g = (last == FETCH) ? DATA : FETCH;
        end else begin
            g = dm_req ? DATA : FETCH;
        end
        return g;
    endfunction

endpackage

// File: rtl/lat_counter.sv
// Loadable down-counter with zero flag; tracks remaining memory latency.
module lat_counter
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] value,
    output logic [CNT_W-1:0] count,
    output logic             zero_c
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Load has priority; decrement saturates at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = value;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count  = count_q;
    assign zero_c = (count_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates F-stage fetch and M-stage data accesses onto one fixed-latency memory.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_valid,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  dm_valid,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  StallF,
    output logic                  StallM
);

    localparam logic [CNT_W-1:0] LAT_M1  = CNT_W'(MEM_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    arb_state_t            state_q,      state_d;
    grant_t                last_grant_q, last_grant_d;
    grant_info_t           gnt_q,        gnt_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,   mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q,  mem_wdata_d;
    logic [DATA_WIDTH-1:0] if_hold_q,    if_hold_d;
    logic [DATA_WIDTH-1:0] dm_hold_q,    dm_hold_d;
    logic                  mem_en_q,     mem_en_d;
    logic                  mem_we_q,     mem_we_d;
    logic                  if_valid_q,   if_valid_d;
    logic                  dm_valid_q,   dm_valid_d;

    logic                  cnt_load_c;
    logic                  cnt_en_c;
    logic                  cnt_zero_c;
    logic [CNT_W-1:0]      cnt_value;

    // Remaining-latency counter, loaded during ISSUE and stepped during WAIT.
    lat_counter u_lat_counter (
        .clk    (clk),
        .rst_n  (reset),
        .load   (cnt_load_c),
        .en     (cnt_en_c),
        .value  (LAT_M1),
        .count  (cnt_value),
        .zero_c (cnt_zero_c)
    );

    // Next-state, grant capture and registered output strobes.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_hold_d    = if_hold_q;
        dm_hold_d    = dm_hold_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        if_valid_d   = 1'b0;
        dm_valid_d   = 1'b0;
        cnt_load_c   = 1'b0;
        cnt_en_c     = 1'b0;

        // Keep the delivered word visible after the valid pulse ends.
        if (if_valid_q) begin
            if_hold_d = mem_rdata;
        end
        if (dm_valid_q && !gnt_q.we) begin
            dm_hold_d = mem_rdata;
        end

        unique case (state_q)
            IDLE: begin
                if (if_req || dm_req) begin
                    gnt_d.id    = pick_grant(if_req, dm_req, last_grant_q);
                    gnt_d.we    = (gnt_d.id == DATA) && dm_we;
                    mem_addr_d  = (gnt_d.id == DATA) ? dm_addr : if_addr;
                    mem_wdata_d = (gnt_d.id == DATA) ? dm_wdata : '0;
                    mem_en_d    = 1'b1;
                    mem_we_d    = gnt_d.we;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                cnt_load_c = 1'b1;
                state_d    = WAIT;
                // Single-cycle latency: the first WAIT cycle is already the data cycle.
                if (LAT_M1 == '0) begin
                    if_valid_d = (gnt_q.id == FETCH);
                    dm_valid_d = (gnt_q.id == DATA);
                end
            end
            WAIT: begin
                if (cnt_zero_c) begin
                    state_d      = IDLE;
                    last_grant_d = gnt_q.id;
                end else begin
                    cnt_en_c = 1'b1;
                    // Counter reaches zero next cycle, which is the valid cycle.
                    if (cnt_value == CNT_ONE) begin
                        if_valid_d = (gnt_q.id == FETCH);
                        dm_valid_d = (gnt_q.id == DATA);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= FETCH;
            gnt_q        <= '{id: FETCH, we: 1'b0};
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_hold_q    <= '0;
            dm_hold_q    <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            if_valid_q   <= 1'b0;
            dm_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_hold_q    <= if_hold_d;
            dm_hold_q    <= dm_hold_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            if_valid_q   <= if_valid_d;
            dm_valid_q   <= dm_valid_d;
        end
    end

    // Read data bypasses straight from memory in the valid cycle.
    assign if_rdata  = if_valid_q ? mem_rdata : if_hold_q;
    assign dm_rdata  = dm_valid_q ? mem_rdata : dm_hold_q;
    assign if_valid  = if_valid_q;
    assign dm_valid  = dm_valid_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign StallF    = if_req & ~if_valid_q;
    assign StallM    = dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (latency 2 and 1) against a schedule-based model.
module tb_mem_arbiter;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    longint      cyc   = 0;
    int          total = 0;
    int          bad   = 0;
    logic        rand_mem = 1'b0;

    logic        if_req    [2];
    logic [31:0] if_addr   [2];
    logic        dm_req    [2];
    logic        dm_we     [2];
    logic [31:0] dm_addr   [2];
    logic [31:0] dm_wdata  [2];
    logic [31:0] mem_rdata [2];
    logic [31:0] if_rdata  [2];
    logic [31:0] dm_rdata  [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic        if_valid  [2];
    logic        dm_valid  [2];
    logic        mem_en    [2];
    logic        mem_we    [2];
    logic        stall_f   [2];
    logic        stall_m   [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint lat_of(input int k);
        return (k == 0) ? 64'd2 : 64'd1;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_arbiter #(
            .DATA_WIDTH (32),
            .ADDR_WIDTH (32),
            .MEM_LATENCY((g == 0) ? 2 : 1)
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .if_req   (if_req[g]),
            .if_addr  (if_addr[g]),
            .if_rdata (if_rdata[g]),
            .if_valid (if_valid[g]),
            .dm_req   (dm_req[g]),
            .dm_we    (dm_we[g]),
            .dm_addr  (dm_addr[g]),
            .dm_wdata (dm_wdata[g]),
            .dm_rdata (dm_rdata[g]),
            .dm_valid (dm_valid[g]),
            .mem_en   (mem_en[g]),
            .mem_we   (mem_we[g]),
            .mem_addr (mem_addr[g]),
            .mem_wdata(mem_wdata[g]),
            .mem_rdata(mem_rdata[g]),
            .StallF   (stall_f[g]),
            .StallM   (stall_m[g])
        );
    end

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] cyc=%0d got=%h want=%h", nm, k, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model: access schedule per instance ----------------
    logic        m_busy  [2];
    logic        m_who   [2];   // 1 = data
    logic        m_we    [2];
    logic        m_last  [2];   // 1 = data was served last
    longint      m_tiss  [2];   // cycle in which mem_en is expected
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic [31:0] m_hif   [2];
    logic [31:0] m_hdm   [2];
    logic        e_en, e_val, e_fv, e_dv;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                chk("rst_mem_en",   k, 32'(mem_en[k]),   32'h0);
                chk("rst_mem_we",   k, 32'(mem_we[k]),   32'h0);
                chk("rst_if_valid", k, 32'(if_valid[k]), 32'h0);
                chk("rst_dm_valid", k, 32'(dm_valid[k]), 32'h0);
                chk("rst_mem_addr", k, mem_addr[k],      32'h0);
                chk("rst_mem_wdata",k, mem_wdata[k],     32'h0);
                chk("rst_if_rdata", k, if_rdata[k],      32'h0);
                chk("rst_dm_rdata", k, dm_rdata[k],      32'h0);
                m_busy[k] = 1'b0; m_last[k] = 1'b0; m_who[k] = 1'b0; m_we[k] = 1'b0;
                m_addr[k] = '0;   m_wdata[k] = '0;  m_hif[k] = '0;   m_hdm[k] = '0;
                m_tiss[k] = 0;
            end else begin
                e_en  = m_busy[k] && (cyc == m_tiss[k]);
                e_val = m_busy[k] && (cyc == m_tiss[k] + lat_of(k));
                e_fv  = e_val && !m_who[k];
                e_dv  = e_val &&  m_who[k];
                chk("mem_en",   k, 32'(mem_en[k]),   32'(e_en));
                chk("mem_we",   k, 32'(mem_we[k]),   32'(e_en && m_we[k]));
                chk("if_valid", k, 32'(if_valid[k]), 32'(e_fv));
                chk("dm_valid", k, 32'(dm_valid[k]), 32'(e_dv));
                chk("StallF",   k, 32'(stall_f[k]),  32'(if_req[k] && !e_fv));
                chk("StallM",   k, 32'(stall_m[k]),  32'(dm_req[k] && !e_dv));
                if (m_busy[k]) chk("mem_addr", k, mem_addr[k], m_addr[k]);
                if (e_en && m_we[k]) chk("mem_wdata", k, mem_wdata[k], m_wdata[k]);
                chk("if_rdata", k, if_rdata[k], e_fv ? mem_rdata[k] : m_hif[k]);
                if (!(e_dv && m_we[k]))
                    chk("dm_rdata", k, dm_rdata[k], e_dv ? mem_rdata[k] : m_hdm[k]);
                // advance the schedule to the next cycle
                if (e_val) begin
                    if (!m_who[k]) m_hif[k] = mem_rdata[k];
                    else if (!m_we[k]) m_hdm[k] = mem_rdata[k];
                    m_last[k] = m_who[k];
                    m_busy[k] = 1'b0;
                end else if (!m_busy[k] && (if_req[k] || dm_req[k])) begin
                    m_who[k]   = (if_req[k] && dm_req[k]) ? !m_last[k] : dm_req[k];
                    m_we[k]    = m_who[k] && dm_we[k];
                    m_addr[k]  = m_who[k] ? dm_addr[k] : if_addr[k];
                    m_wdata[k] = dm_wdata[k];
                    m_tiss[k]  = cyc + 1;
                    m_busy[k]  = 1'b1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic to_next();
        @(posedge clk);
        #1;
        if (rand_mem) for (int k = 0; k < 2; k++) mem_rdata[k] = $urandom;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    logic   p_if [2], p_dm [2], g_if [2], g_dm [2];
    int     w_if [2], w_dm [2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            if_req[k] = 0; if_addr[k] = 0; dm_req[k] = 0; dm_we[k] = 0;
            dm_addr[k] = 0; dm_wdata[k] = 0;
            p_if[k] = 0; p_dm[k] = 0; g_if[k] = 0; g_dm[k] = 0; w_if[k] = 0; w_dm[k] = 0;
        end
        mem_rdata[0] = 32'h0050_0093;
        mem_rdata[1] = 32'h1234_5678;
        repeat (3) to_next();

        // Both requesters right after reset, held for four accesses.
        to_next();
        reset = 1'b1;
        if_req[0] = 1; if_addr[0] = 32'h0000_0040;
        dm_req[0] = 1; dm_we[0] = 0; dm_addr[0] = 32'h0000_0800;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) to_next();
            to_neg();
            chk("t4_mem_en",   0, 32'(mem_en[0]),   32'((c % 4) == 1));
            chk("t4_dm_valid", 0, 32'(dm_valid[0]), 32'(c == 3 || c == 11));
            chk("t4_if_valid", 0, 32'(if_valid[0]), 32'(c == 7 || c == 15));
            chk("t4_StallF",   0, 32'(stall_f[0]),  32'(!(c == 7 || c == 15)));
            chk("t4_StallM",   0, 32'(stall_m[0]),  32'(!(c == 3 || c == 11)));
            if (c == 1) chk("t4_addr_data",  0, mem_addr[0], 32'h0000_0800);
            if (c == 5) chk("t4_addr_fetch", 0, mem_addr[0], 32'h0000_0040);
            if (c == 3) chk("t4_dm_rdata",   0, dm_rdata[0], 32'h0050_0093);
        end
        to_next();
        if_req[0] = 0; dm_req[0] = 0;

        // Fetch only at 0x10.
        to_next();
        if_req[0] = 1; if_addr[0] = 32'h0000_0010;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) to_next();
            to_neg();
            chk("t1_mem_en",   0, 32'(mem_en[0]),   32'(c == 1));
            chk("t1_mem_we",   0, 32'(mem_we[0]),   32'h0);
            chk("t1_if_valid", 0, 32'(if_valid[0]), 32'(c == 3));
            chk("t1_StallF",   0, 32'(stall_f[0]),  32'(c != 3));
            if (c == 1) chk("t1_mem_addr", 0, mem_addr[0], 32'h0000_0010);
            if (c == 3) chk("t1_if_rdata", 0, if_rdata[0], 32'h0050_0093);
        end
        to_next();
        if_req[0] = 0;

        // Store only.
        to_next();
        dm_req[0] = 1; dm_we[0] = 1; dm_addr[0] = 32'h0000_0100; dm_wdata[0] = 32'hDEAD_BEEF;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) to_next();
            to_neg();
            chk("t2_mem_en",   0, 32'(mem_en[0]),   32'(c == 1));
            chk("t2_mem_we",   0, 32'(mem_we[0]),   32'(c == 1));
            chk("t2_dm_valid", 0, 32'(dm_valid[0]), 32'(c == 3));
            chk("t2_StallM",   0, 32'(stall_m[0]),  32'(c != 3));
            if (c == 1) begin
                chk("t2_mem_addr",  0, mem_addr[0],  32'h0000_0100);
                chk("t2_mem_wdata", 0, mem_wdata[0], 32'hDEAD_BEEF);
            end
        end
        to_next();
        dm_req[0] = 0; dm_we[0] = 0;

        // Reset during WAIT of a load, then a fresh load.
        to_next();
        dm_req[0] = 1; dm_addr[0] = 32'h0000_0200;
        to_next();
        to_next();
        reset = 1'b0; dm_req[0] = 0;
        to_neg();
        chk("t5_dm_valid", 0, 32'(dm_valid[0]), 32'h0);
        chk("t5_mem_addr", 0, mem_addr[0],      32'h0);
        chk("t5_mem_en",   0, 32'(mem_en[0]),   32'h0);
        to_next();
        to_neg();
        chk("t5_dm_valid_late", 0, 32'(dm_valid[0]), 32'h0);
        to_next();
        reset = 1'b1;
        dm_req[0] = 1; dm_addr[0] = 32'h0000_0300;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) to_next();
            to_neg();
            chk("t5_re_mem_en",   0, 32'(mem_en[0]),   32'(c == 1));
            chk("t5_re_dm_valid", 0, 32'(dm_valid[0]), 32'(c == 3));
            if (c == 3) chk("t5_re_dm_rdata", 0, dm_rdata[0], 32'h0050_0093);
        end
        to_next();
        dm_req[0] = 0;

        // Latency 1 instance: fetch at 0x4, request held into a second access.
        to_next();
        if_req[1] = 1; if_addr[1] = 32'h0000_0004;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) to_next();
            to_neg();
            chk("t6_mem_en",   1, 32'(mem_en[1]),   32'(c == 1 || c == 4));
            chk("t6_if_valid", 1, 32'(if_valid[1]), 32'(c == 2 || c == 5));
            if (c == 1) chk("t6_mem_addr", 1, mem_addr[1], 32'h0000_0004);
            if (c == 2) chk("t6_if_rdata", 1, if_rdata[1], 32'h1234_5678);
        end
        to_next();
        if_req[1] = 0;
        to_next();

        // Randomized traffic on both instances.
        rand_mem = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            to_next();
            for (int k = 0; k < 2; k++) begin
                if (p_if[k] && g_if[k]) begin p_if[k] = 0; if_req[k] = 0; end
                if (p_dm[k] && g_dm[k]) begin p_dm[k] = 0; dm_req[k] = 0; end
                if (!p_if[k] && n < 2950 && $urandom_range(2) == 0) begin
                    p_if[k] = 1; w_if[k] = 0; if_req[k] = 1;
                    if_addr[k] = $urandom & 32'hFFFF_FFFC;
                end
                if (!p_dm[k] && n < 2950 && $urandom_range(2) == 0) begin
                    p_dm[k] = 1; w_dm[k] = 0; dm_req[k] = 1;
                    dm_we[k] = 1'($urandom_range(1));
                    dm_addr[k] = $urandom & 32'hFFFF_FFFC;
                    dm_wdata[k] = $urandom;
                end
                if (p_if[k]) w_if[k]++;
                if (p_dm[k]) w_dm[k]++;
                if (w_if[k] > 40) begin
                    total++; bad++;
                    $display("FAIL if_timeout[%0d] cyc=%0d got=no_valid want=valid", k, cyc);
                    p_if[k] = 0; if_req[k] = 0; w_if[k] = 0;
                end
                if (w_dm[k] > 40) begin
                    total++; bad++;
                    $display("FAIL dm_timeout[%0d] cyc=%0d got=no_valid want=valid", k, cyc);
                    p_dm[k] = 0; dm_req[k] = 0; w_dm[k] = 0;
                end
            end
            to_neg();
            for (int k = 0; k < 2; k++) begin
                g_if[k] = if_valid[k];
                g_dm[k] = dm_valid[k];
            end
        end
        for (int k = 0; k < 2; k++) begin
            if_req[k] = 0; dm_req[k] = 0;
        end
        repeat (5) to_next();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
